// File: rtl/mole_pkg.sv
// Shared constants, state encoding and LFSR step for the whack-a-mole answer-pattern path.
package mole_pkg;

    localparam int NUM_SLOTS = 8;
    localparam int NIBBLE_W  = 4;
    localparam int SLOT_W    = $clog2(NUM_SLOTS);

    // Galois taps for x^32 + x^22 + x^2 + x + 1
    localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

    typedef enum logic [1:0] {
        IDLE,
        GEN,
        DONE
    } state_t;

    function automatic logic [31:0] lfsr_next(input logic [31:0] value);
        return value[0] ? ((value >> 1) ^ LFSR_MASK) : (value >> 1);
    endfunction

endpackage

// File: rtl/mole_lfsr32.sv
// Free-running 32-bit Galois LFSR; a zero seed is replaced by 1 so the register never locks up.
module mole_lfsr32
    import mole_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] seed,
    output logic [31:0] value
);

    logic [31:0] seed_safe;

    assign seed_safe = (seed == 32'd0) ? 32'd1 : seed;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value <= seed_safe;
        end else begin
            value <= lfsr_next(value);
        end
    end

endmodule

// File: rtl/mole_pattern_gen.sv
// Builds 8-nibble mole answer words from an LFSR with rejection sampling and a forced fallback.
// Define MOLE_NO_REPEAT_EN to forbid the same hole in adjacent slots, including across words.
module mole_pattern_gen
    import mole_pkg::*;
#(
    parameter int          NUM_HOLES  = 9,
    parameter logic [31:0] SEED       = 32'hACE1_2023,
    parameter int          MAX_REJECT = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        game_start,
    output logic [31:0] data_out,
    output logic        write_enable,
    output logic        busy,
    output logic [7:0]  pattern_count
);

    localparam int REJ_W = (MAX_REJECT < 1) ? 1 : $clog2(MAX_REJECT + 1);

    state_t              state, state_next;
    logic [SLOT_W-1:0]   slot, slot_next, prev_slot;
    logic [REJ_W-1:0]    rej, rej_next;
    logic [31:0]         shadow, shadow_next;
    logic                pending, pending_next;
    logic [31:0]         lfsr;
    logic                start;
    logic [NIBBLE_W-1:0] cand, prev, fallback;
    logic [NIBBLE_W:0]   prev_inc;
    logic                in_range, repeat_ok, accept;

    mole_lfsr32 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .seed  (SEED),
        .value (lfsr)
    );

    assign start     = req | game_start;
    assign cand      = lfsr[NIBBLE_W-1:0];
    assign prev_slot = slot - SLOT_W'(1);

    // Slot 0 has no in-word predecessor; with the no-repeat rule it chains off the last delivered word.
`ifdef MOLE_NO_REPEAT_EN
    assign prev = (slot == '0) ? data_out[31:28] : shadow[prev_slot*NIBBLE_W +: NIBBLE_W];
`else
    assign prev = (slot == '0) ? '0 : shadow[prev_slot*NIBBLE_W +: NIBBLE_W];
`endif

    assign prev_inc = {1'b0, prev} + (NIBBLE_W+1)'(1);
    assign fallback = (prev_inc == (NIBBLE_W+1)'(NUM_HOLES)) ? '0 : prev_inc[NIBBLE_W-1:0];
    assign in_range = ({1'b0, cand} < (NIBBLE_W+1)'(NUM_HOLES));

`ifdef MOLE_NO_REPEAT_EN
    assign repeat_ok = (cand != prev);
`else
    assign repeat_ok = 1'b1;
`endif

    assign accept = in_range & repeat_ok;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
        state_next   = state;
        slot_next    = slot;
        rej_next     = rej;
        shadow_next  = shadow;
        pending_next = pending;

        unique case (state)
            IDLE: begin
                if (start || pending) begin
                    slot_next    = '0;
                    rej_next     = '0;
                    shadow_next  = '0;
                    pending_next = 1'b0;
                    state_next   = GEN;
                end
            end
            GEN: begin
                if (start) pending_next = 1'b1;
                if (accept || rej == REJ_W'(MAX_REJECT)) begin
                    shadow_next[slot*NIBBLE_W +: NIBBLE_W] = accept ? cand : fallback;
                    slot_next = slot + SLOT_W'(1);
                    rej_next  = '0;
                    if (slot == SLOT_W'(NUM_SLOTS - 1)) state_next = DONE;
                end else begin
                    rej_next = rej + REJ_W'(1);
                end
            end
            DONE: begin
                if (start) pending_next = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // The partial shadow word is cleared by reset, so an interrupted build can never be delivered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            slot          <= '0;
            rej           <= '0;
            shadow        <= '0;
            pending       <= 1'b0;
            data_out      <= '0;
            write_enable  <= 1'b0;
            busy          <= 1'b0;
            pattern_count <= '0;
        end else begin
            state        <= state_next;
            slot         <= slot_next;
            rej          <= rej_next;
            shadow       <= shadow_next;
            pending      <= pending_next;
            busy         <= (state_next != IDLE);
            write_enable <= (state_next == DONE);
            if (state_next == DONE) begin
                data_out      <= shadow_next;
                pattern_count <= pattern_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_mole_pattern_gen.sv
// Randomized self-checking bench for mole_pattern_gen against a word-level reference model.
module tb_mole_pattern_gen;

    localparam logic [31:0] SEED = 32'hACE1_2023;
    localparam logic [31:0] POLY = 32'h8020_0003;
`ifdef MOLE_NO_REPEAT_EN
    localparam bit NOREP = 1'b1;
`else
    localparam bit NOREP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        req [3];
    logic        gs [3];
    logic [31:0] dout [3];
    logic        we [3];
    logic        busy [3];
    logic [7:0]  cnt [3];
    logic [31:0] m_lfsr;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mole_pattern_gen #(.NUM_HOLES(16)) dut_a (
        .clk(clk), .reset(reset), .req(req[0]), .game_start(gs[0]), .data_out(dout[0]),
        .write_enable(we[0]), .busy(busy[0]), .pattern_count(cnt[0]));
    mole_pattern_gen #(.NUM_HOLES(9)) dut_b (
        .clk(clk), .reset(reset), .req(req[1]), .game_start(gs[1]), .data_out(dout[1]),
        .write_enable(we[1]), .busy(busy[1]), .pattern_count(cnt[1]));
    mole_pattern_gen #(.NUM_HOLES(2)) dut_c (
        .clk(clk), .reset(reset), .req(req[2]), .game_start(gs[2]), .data_out(dout[2]),
        .write_enable(we[2]), .busy(busy[2]), .pattern_count(cnt[2]));

    function automatic logic [31:0] step(input logic [31:0] v);
        return v[0] ? ((v >> 1) ^ POLY) : (v >> 1);
    endfunction

    function automatic logic [31:0] step_n(input logic [31:0] v, input int n);
        logic [31:0] r = v;
        for (int i = 0; i < n; i++) r = step(r);
        return r;
    endfunction

    function automatic int holes_of(input int d);
        return (d == 0) ? 16 : (d == 1) ? 9 : 2;
    endfunction

    // Word-level model: one candidate per cycle, starting from the LFSR value of the first GEN cycle.
    function automatic void predict(input logic [31:0] start, input int holes, input logic [3:0] last,
                                    output logic [31:0] word, output int gen, output bit slot0_forced);
        logic [31:0] l = start;
        int slot = 0, rej = 0, c, p;
        bit ok;
        word = 0; gen = 0; slot0_forced = 0;
        while (slot < 8) begin
            c  = int'(l[3:0]);
            p  = (slot == 0) ? (NOREP ? int'(last) : 0) : int'((word >> (4 * (slot - 1))) & 32'hF);
            ok = (c < holes) && !(NOREP && c == p);
            if (ok || rej == 7) begin
                if (!ok && slot == 0) slot0_forced = 1;
                word = word | (32'(ok ? c : (p + 1) % holes) << (4 * slot));
                slot++;
                rej = 0;
            end else begin
                rej++;
            end
            l = step(l);
            gen++;
        end
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) m_lfsr <= SEED;
        else       m_lfsr <= step(m_lfsr);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Issues one request to an idle DUT, waits for the strobe and checks word and latency.
    task automatic deliver(input int d, input bit r, input bit g, output logic [31:0] word);
        logic [31:0] exp_w;
        int n, lat;
        bit f;
        predict(step(m_lfsr), holes_of(d), dout[d][31:28], exp_w, n, f);
        req[d] = r;
        gs[d]  = g;
        lat    = -1;
        for (int c = 1; c <= 200; c++) begin
            tick();
            req[d] = 1'b0;
            gs[d]  = 1'b0;
            if (we[d]) begin
                lat = c;
                break;
            end
        end
        if (lat < 0) check("deliver_timeout", 32'd0, 32'd1);
        check("deliver_latency", 32'(lat), 32'(n + 1));
        check("deliver_word", dout[d], exp_w);
        word = dout[d];
        tick();
    endtask

    initial begin
        logic [31:0] w, m0, exp_w, w1, w2, got_w, got_w2;
        logic [15:0] busy_bits, we_bits, exp_busy, exp_we;
        logic [7:0]  c0;
        logic [3:0]  p;
        int n, n2, done1, done2, pulses, p1, p2;
        bit f, bad, found, we_seen;

        for (int d = 0; d < 3; d++) begin
            req[d] = 1'b0;
            gs[d]  = 1'b0;
        end
        reset = 1'b1;
        repeat (3) tick();
        for (int d = 0; d < 3; d++) begin
            check("rst_data", dout[d], 32'd0);
            check("rst_we", 32'(we[d]), 32'd0);
            check("rst_busy", 32'(busy[d]), 32'd0);
            check("rst_count", 32'(cnt[d]), 32'd0);
        end
        reset = 1'b0;
        repeat (2) tick();

        // Fixed latency on the 16-hole instance: candidates are the raw LFSR nibbles
        m0 = m_lfsr;
        predict(step(m0), 16, dout[0][31:28], exp_w, n, f);
        if (!NOREP) begin
            exp_w = 0;
            for (int k = 0; k < 8; k++) exp_w[4*k +: 4] = step_n(m0, k + 1) >> 0;
            n = 8;
        end
        exp_busy = 0;
        exp_we   = 0;
        for (int c = 1; c <= n + 1; c++) exp_busy[c] = 1'b1;
        exp_we[n + 1] = 1'b1;
        busy_bits = 0;
        we_bits   = 0;
        got_w     = 0;
        req[0] = 1'b1;
        for (int c = 1; c < 16; c++) begin
            tick();
            req[0] = 1'b0;
            busy_bits[c] = busy[0];
            we_bits[c]   = we[0];
            if (we[0]) got_w = dout[0];
        end
        if (!NOREP) check("lat_busy_1to9", 32'(busy_bits), 32'h0000_03FE);
        check("lat_busy", 32'(busy_bits), 32'(exp_busy));
        check("lat_we", 32'(we_bits), 32'(exp_we));
        check("lat_word", got_w, exp_w);
        check("lat_count", 32'(cnt[0]), 32'd1);

        // Reset in the middle of a build
        req[0] = 1'b1;
        tick();
        req[0] = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        #1;
        check("midrst_data", dout[0], 32'd0);
        check("midrst_we", 32'(we[0]), 32'd0);
        check("midrst_busy", 32'(busy[0]), 32'd0);
        check("midrst_count", 32'(cnt[0]), 32'd0);
        repeat (2) tick();
        reset = 1'b0;
        we_seen = 0;
        repeat (20) begin
            tick();
            we_seen |= we[0] | we[1] | we[2];
        end
        check("midrst_quiet", 32'(we_seen), 32'd0);

        // Range and counter wrap on the 9-hole instance with random request timing and sources
        for (int i = 0; i < 500; i++) begin
            int sel;
            repeat ($urandom_range(0, 3)) tick();
            sel = $urandom_range(0, 2);
            deliver(1, sel != 1, sel != 0, w);
            bad = 0;
            for (int k = 0; k < 8; k++) if (w[4*k +: 4] > 4'd8) bad = 1;
            check("range_nibble", 32'(bad), 32'd0);
            if (i == 255) check("count_wrap", 32'(cnt[1]), 32'd0);
        end
        check("count_final", 32'(cnt[1]), 32'(500 % 256));

        // Fallback: time a request so slot 0 sees eight rejected candidates
        found = 0;
        for (int c = 0; c < 20000; c++) begin
            predict(step(m_lfsr), 9, dout[1][31:28], exp_w, n, f);
            if (f) begin
                found = 1;
                break;
            end
            tick();
        end
        check("fb_found", 32'(found), 32'd1);
        if (found) begin
            deliver(1, 1'b1, 1'b0, w);
            if (!NOREP) check("fb_slot0", 32'(w[3:0]), 32'd1);
            check("fb_extra_cycles", 32'(n - 8 >= 7), 32'd1);
        end

        // Requests while busy: one absorbed into pending, the rest dropped
        repeat (2) tick();
        m0 = m_lfsr;
        c0 = cnt[0];
        predict(step(m0), 16, dout[0][31:28], w1, n, f);
        done1 = n + 1;
        predict(step_n(m0, done1 + 2), 16, w1[31:28], w2, n2, f);
        done2 = done1 + 2 + n2;
        pulses = 0; p1 = -1; p2 = -1; got_w = 0; got_w2 = 0;
        req[0] = 1'b1;
        for (int c = 1; c <= 200; c++) begin
            tick();
            if (we[0]) begin
                pulses++;
                if (pulses == 1) begin p1 = c; got_w = dout[0]; end
                if (pulses == 2) begin p2 = c; got_w2 = dout[0]; end
            end
            req[0] = (c == 3) || (c == 5);
            gs[0]  = (c == 9);
        end
        check("busy_pulses", 32'(pulses), 32'd2);
        if (!NOREP) begin
            check("busy_p1_cycle9", 32'(p1), 32'd9);
            check("busy_p2_cycle19", 32'(p2), 32'd19);
        end
        check("busy_p1", 32'(p1), 32'(done1));
        check("busy_p2", 32'(p2), 32'(done2));
        check("busy_word1", got_w, w1);
        check("busy_word2", got_w2, w2);
        check("busy_count", 32'(cnt[0]), 32'(c0 + 8'd2));

`ifdef MOLE_NO_REPEAT_EN
        for (int i = 0; i < 1000; i++) begin
            p = dout[2][31:28];
            deliver(2, 1'b1, 1'b0, w);
            bad = 0;
            for (int k = 0; k < 8; k++) begin
                if (w[4*k +: 4] == p) bad = 1;
                p = w[4*k +: 4];
            end
            check("norep_adjacent", 32'(bad), 32'd0);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
